mem_port_arbiter: RTL and testbench

Shares the single external memory port between the instruction-fetch requester and the load/store requester. Sits between the pipeline front/back ends and the external bus. Grants one transaction at a time and holds the bus request stable until the memory acknowledges. LSU requests have priority, with a starvation guard that protects fetch; an optional watchdog aborts hung accesses.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory port arbiter, its two requesters and the external memory bus.
// The arbiter uses the slave modport; the environment (requesters plus memory) uses master.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;

   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [3:0]  ls_be;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;
   logic        ls_err;

   logic        ext_req;
   logic        ext_we;
   logic [31:0] ext_addr;
   logic [31:0] ext_wdata;
   logic [3:0]  ext_be;
   logic        ext_ready;
   logic [31:0] ext_data_in;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, ext_ready, ext_data_in,
      output if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
             ext_req, ext_we, ext_addr, ext_wdata, ext_be
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, ext_ready, ext_data_in,
      input  if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
             ext_req, ext_we, ext_addr, ext_wdata, ext_be
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and load/store (LSU priority
// with a fetch starvation guard). Define MEM_ARB_TIMEOUT_EN to enable the hung-access watchdog.
module mem_port_arbiter #(
   parameter int unsigned MAX_LS_BURST   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
   localparam logic [3:0]  BURST_MAX = 4'(MAX_LS_BURST);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

   if (MAX_LS_BURST < 1 || MAX_LS_BURST > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255)
   begin : g_param_check
      $error("mem_port_arbiter: parameter out of range");
   end

   state_t      r_state;
   state_t      w_next;
   logic        w_grant_if;
   logic        w_grant_ls;
   logic        w_done;
   logic        w_abort;
   logic [3:0]  r_burst;
   logic        r_if_gnt, r_if_rvalid, r_ls_gnt, r_ls_rvalid;
   logic [31:0] r_if_rdata, r_ls_rdata;
   logic        r_ext_req, r_ext_we;
   logic [31:0] r_ext_addr, r_ext_wdata;
   logic [3:0]  r_ext_be;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // LSU wins a tie unless it has already taken BURST_MAX grants in a row past a waiting fetch
   always_comb begin
      w_next     = r_state;
      w_grant_if = 1'b0;
      w_grant_ls = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.ls_req && !(bus.if_req && r_burst == BURST_MAX)) begin
               w_grant_ls = 1'b1;
               w_next     = BUSY_LS;
            end else if (bus.if_req) begin
               w_grant_if = 1'b1;
               w_next     = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_LS: begin
            if (bus.ext_ready || w_abort) begin
               w_done = 1'b1;
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_burst     <= 4'd0;
         r_if_gnt    <= 1'b0;
         r_ls_gnt    <= 1'b0;
         r_if_rvalid <= 1'b0;
         r_ls_rvalid <= 1'b0;
         r_if_rdata  <= NOP_INSN;
         r_ls_rdata  <= 32'd0;
         r_ext_req   <= 1'b0;
         r_ext_we    <= 1'b0;
         r_ext_addr  <= 32'd0;
         r_ext_wdata <= 32'd0;
         r_ext_be    <= 4'd0;
      end else begin
         r_if_gnt    <= w_grant_if;
         r_ls_gnt    <= w_grant_ls;
         r_if_rvalid <= w_done && (r_state == BUSY_IF);
         r_ls_rvalid <= w_done && (r_state == BUSY_LS);

         if (w_grant_if) begin
            r_burst <= 4'd0;
         end else if (w_grant_ls) begin
            if (!bus.if_req)              r_burst <= 4'd0;
            else if (r_burst != BURST_MAX) r_burst <= r_burst + 4'd1;
         end

         // Bus payload is captured on grant and held untouched until completion
         if (w_grant_if) begin
            r_ext_req   <= 1'b1;
            r_ext_we    <= 1'b0;
            r_ext_be    <= 4'hF;
            r_ext_wdata <= 32'd0;
            r_ext_addr  <= {bus.if_addr[31:2], 2'b00};
         end else if (w_grant_ls) begin
            r_ext_req   <= 1'b1;
            r_ext_we    <= bus.ls_we;
            r_ext_be    <= bus.ls_be;
            r_ext_wdata <= bus.ls_wdata;
            r_ext_addr  <= {bus.ls_addr[31:2], 2'b00};
         end else if (w_done) begin
            r_ext_req   <= 1'b0;
            r_ext_we    <= 1'b0;
            r_ext_be    <= 4'd0;
            r_ext_wdata <= 32'd0;
         end

         if (w_done && r_state == BUSY_IF)
            r_if_rdata <= w_abort ? NOP_INSN : bus.ext_data_in;
         if (w_done && r_state == BUSY_LS && (w_abort || !r_ext_we))
            r_ls_rdata <= w_abort ? 32'd0 : bus.ext_data_in;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_to_cnt;
   logic       r_if_err, r_ls_err;

   // A ready in the limit cycle still completes normally
   assign w_abort = (r_state != IDLE) && !bus.ext_ready && (r_to_cnt == TO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_to_cnt <= 8'd0;
         r_if_err <= 1'b0;
         r_ls_err <= 1'b0;
      end else begin
         r_if_err <= w_abort && (r_state == BUSY_IF);
         r_ls_err <= w_abort && (r_state == BUSY_LS);
         if (w_grant_if || w_grant_ls)
            r_to_cnt <= 8'd0;
         else if (r_state != IDLE && !bus.ext_ready)
            r_to_cnt <= r_to_cnt + 8'd1;
      end
   end

   assign bus.if_err = r_if_err;
   assign bus.ls_err = r_ls_err;
`else
   assign w_abort    = 1'b0;
   assign bus.if_err = 1'b0;
   assign bus.ls_err = 1'b0;
`endif

   assign bus.if_gnt    = r_if_gnt;
   assign bus.if_rvalid = r_if_rvalid;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.ls_gnt    = r_ls_gnt;
   assign bus.ls_rvalid = r_ls_rvalid;
   assign bus.ls_rdata  = r_ls_rdata;
   assign bus.ext_req   = r_ext_req;
   assign bus.ext_we    = r_ext_we;
   assign bus.ext_addr  = r_ext_addr;
   assign bus.ext_wdata = r_ext_wdata;
   assign bus.ext_be    = r_ext_be;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int unsigned MAX_BURST = 4;
   localparam int unsigned TIMEOUT   = 16;
   localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

   typedef struct {
      logic        is_ls;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] mem_data;
      int          waits;
      logic [31:0] exp_addr;
      logic        exp_we;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(
      .MAX_LS_BURST   (MAX_BURST),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.if_req      = 1'b0;
      bus.if_addr     = 32'd0;
      bus.ls_req      = 1'b0;
      bus.ls_we       = 1'b0;
      bus.ls_addr     = 32'd0;
      bus.ls_wdata    = 32'd0;
      bus.ls_be       = 4'd0;
      bus.ext_ready   = 1'b0;
      bus.ext_data_in = 32'd0;
   endtask

   task automatic check_reset_state(input string t);
      check({t, "_if_gnt"},    32'(bus.if_gnt),    32'd0);
      check({t, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
      check({t, "_if_err"},    32'(bus.if_err),    32'd0);
      check({t, "_if_rdata"},  bus.if_rdata,       NOP_INSN);
      check({t, "_ls_gnt"},    32'(bus.ls_gnt),    32'd0);
      check({t, "_ls_rvalid"}, 32'(bus.ls_rvalid), 32'd0);
      check({t, "_ls_err"},    32'(bus.ls_err),    32'd0);
      check({t, "_ls_rdata"},  bus.ls_rdata,       32'd0);
      check({t, "_ext_req"},   32'(bus.ext_req),   32'd0);
      check({t, "_ext_we"},    32'(bus.ext_we),    32'd0);
      check({t, "_ext_addr"},  bus.ext_addr,       32'd0);
      check({t, "_ext_wdata"}, bus.ext_wdata,      32'd0);
      check({t, "_ext_be"},    32'(bus.ext_be),    32'd0);
   endtask

   task automatic check_bus(input string t, input vec_t v);
      check({t, "_ext_req"},   32'(bus.ext_req), 32'd1);
      check({t, "_ext_addr"},  bus.ext_addr,     v.exp_addr);
      check({t, "_ext_we"},    32'(bus.ext_we),  32'(v.exp_we));
      check({t, "_ext_be"},    32'(bus.ext_be),  32'(v.exp_be));
      check({t, "_ext_wdata"}, bus.ext_wdata,    v.exp_wdata);
   endtask

   // One isolated access from the table, with v.waits cycles of ext_ready low
   task automatic do_txn(input vec_t v, input int idx);
      string t;
      t = $sformatf("vec%0d", idx);
      if (v.is_ls) begin
         bus.ls_req   = 1'b1;
         bus.ls_we    = v.we;
         bus.ls_addr  = v.addr;
         bus.ls_wdata = v.wdata;
         bus.ls_be    = v.be;
      end else begin
         bus.if_req  = 1'b1;
         bus.if_addr = v.addr;
      end
      bus.ext_ready = 1'b0;
      step();
      check({t, "_gnt"},       32'(v.is_ls ? bus.ls_gnt : bus.if_gnt), 32'd1);
      check({t, "_other_gnt"}, 32'(v.is_ls ? bus.if_gnt : bus.ls_gnt), 32'd0);
      check_bus({t, "_grant"}, v);
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      for (int w = 0; w <= v.waits; w++) begin
         bus.ext_ready   = (w == v.waits);
         bus.ext_data_in = (w == v.waits) ? v.mem_data : $urandom;
         step();
         if (w < v.waits) begin
            check_bus($sformatf("%s_wait%0d", t, w), v);
            check({t, "_early_rvalid"}, 32'(v.is_ls ? bus.ls_rvalid : bus.if_rvalid), 32'd0);
         end else begin
            check({t, "_rvalid"},  32'(v.is_ls ? bus.ls_rvalid : bus.if_rvalid), 32'd1);
            check({t, "_rdata"},   v.is_ls ? bus.ls_rdata : bus.if_rdata, v.exp_rdata);
            check({t, "_req_off"}, 32'(bus.ext_req), 32'd0);
         end
      end
      bus.ext_ready = 1'b0;
      step();
      check({t, "_rvalid_pulse"}, 32'(v.is_ls ? bus.ls_rvalid : bus.if_rvalid), 32'd0);
   endtask

   // Transaction-level model: who may win, what the bus must carry, what comes back
   task automatic random_test(input int cycles);
      bit          busy = 1'b0, owner_ls = 1'b0, got_if = 1'b0, got_ls = 1'b0;
      bit          e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv;
      int          ls_run = 0;   // LSU grants taken in a row while fetch kept waiting
      logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_if_rd = NOP_INSN, m_ls_rd = 32'd0;
      logic        m_we = 1'b0;
      logic [3:0]  m_be = 4'd0;
      for (int c = 0; c < cycles; c++) begin
         if (got_if || !bus.if_req) begin
            bus.if_req  = ($urandom % 2) == 0;
            bus.if_addr = $urandom;
         end
         if (got_ls || !bus.ls_req) begin
            bus.ls_req   = ($urandom % 3) != 0;
            bus.ls_we    = 1'($urandom % 2);
            bus.ls_addr  = $urandom;
            bus.ls_wdata = $urandom;
            bus.ls_be    = 4'($urandom);
         end
         bus.ext_ready   = ($urandom % 4) != 0;
         bus.ext_data_in = $urandom;
         step();

         e_if_gnt = 1'b0; e_ls_gnt = 1'b0; e_if_rv = 1'b0; e_ls_rv = 1'b0;
         if (!busy) begin
            if (bus.ls_req && !(bus.if_req && ls_run == int'(MAX_BURST))) begin
               e_ls_gnt = 1'b1; owner_ls = 1'b1; busy = 1'b1;
               ls_run   = bus.if_req ? ls_run + 1 : 0;
               m_addr   = {bus.ls_addr[31:2], 2'b00};
               m_we = bus.ls_we; m_be = bus.ls_be; m_wdata = bus.ls_wdata;
            end else if (bus.if_req) begin
               e_if_gnt = 1'b1; owner_ls = 1'b0; busy = 1'b1; ls_run = 0;
               m_addr   = {bus.if_addr[31:2], 2'b00};
               m_we = 1'b0; m_be = 4'hF; m_wdata = 32'd0;
            end
         end else if (bus.ext_ready) begin
            busy = 1'b0;
            if (owner_ls) begin
               e_ls_rv = 1'b1;
               if (!m_we) m_ls_rd = bus.ext_data_in;
            end else begin
               e_if_rv = 1'b1;
               m_if_rd = bus.ext_data_in;
            end
         end
         got_if = e_if_gnt;
         got_ls = e_ls_gnt;

         check("rnd_if_gnt",    32'(bus.if_gnt),    32'(e_if_gnt));
         check("rnd_ls_gnt",    32'(bus.ls_gnt),    32'(e_ls_gnt));
         check("rnd_if_rvalid", 32'(bus.if_rvalid), 32'(e_if_rv));
         check("rnd_ls_rvalid", 32'(bus.ls_rvalid), 32'(e_ls_rv));
         check("rnd_ext_req",   32'(bus.ext_req),   32'(busy));
         check("rnd_ext_addr",  bus.ext_addr,       m_addr);
         check("rnd_ext_we",    32'(bus.ext_we),    busy ? 32'(m_we) : 32'd0);
         check("rnd_ext_be",    32'(bus.ext_be),    busy ? 32'(m_be) : 32'd0);
         check("rnd_ext_wdata", bus.ext_wdata,      busy ? m_wdata : 32'd0);
         check("rnd_if_rdata",  bus.if_rdata,       m_if_rd);
         check("rnd_ls_rdata",  bus.ls_rdata,       m_ls_rd);
      end
   endtask

   initial begin
      vec_t        vecs[6];
      int          n;
      int          grants;
      logic        saw_ls;
      logic [31:0] tmp;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0102, 32'h0, 4'h0, 32'hDEAD_BEEF, 0,
                  32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_1007, 32'hCAFE_F00D, 4'hC, 32'h1234_5678, 1,
                  32'h0000_1004, 1'b0, 4'hC, 32'hCAFE_F00D, 32'h1234_5678};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 4'h3, 32'hFFFF_FFFF, 3,
                  32'h0000_2000, 1'b1, 4'h3, 32'hA5A5_A5A5, 32'h1234_5678};
      vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 32'h0BAD_F00D, 2,
                  32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D};
      vecs[4] = '{1'b1, 1'b1, 32'h0000_0003, 32'h0, 4'hF, 32'h5555_AAAA, 0,
                  32'h0000_0000, 1'b1, 4'hF, 32'h0, 32'h1234_5678};
      vecs[5] = '{1'b1, 1'b0, 32'h8000_0000, 32'h1, 4'h1, 32'h0000_0000, 0,
                  32'h8000_0000, 1'b0, 4'h1, 32'h1, 32'h0000_0000};

      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("por");
      reset = 1'b0;
      step();

      for (int i = 0; i < 6; i++) do_txn(vecs[i], i);

      // Reset asserted mid-access with ready pending: no completion may escape
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h0000_0500; bus.ls_be = 4'hF;
      step();
      check("rstmid_ls_gnt", 32'(bus.ls_gnt), 32'd1);
      bus.ls_req = 1'b0; bus.ext_ready = 1'b1; bus.ext_data_in = 32'h7777_7777;
      #2 reset = 1'b1;
      #1;
      check_reset_state("rstmid");
      step();
      check("rstmid_no_rvalid", 32'(bus.ls_rvalid), 32'd0);
      bus.ext_ready = 1'b0;
      reset = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0044;
      step();
      check("rstmid_if_gnt",    32'(bus.if_gnt),    32'd1);
      check("rstmid_ext_addr",  bus.ext_addr,       32'h0000_0044);
      check("rstmid_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
      bus.if_req = 1'b0; bus.ext_ready = 1'b1; bus.ext_data_in = 32'h0101_0202;
      step();
      check("rstmid_if_rvalid", 32'(bus.if_rvalid), 32'd1);
      check("rstmid_if_rdata",  bus.if_rdata,       32'h0101_0202);
      bus.ext_ready = 1'b0;
      step();

      // Hung fetch: watchdog aborts, or without it the request stays up
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0400; bus.ext_ready = 1'b0;
      step();
      bus.if_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      n = 0;
      while (bus.ext_req && n < 100) begin
         n++;
         step();
      end
      check("to_busy_cycles", 32'(n),             32'(TIMEOUT));
      check("to_ext_req",     32'(bus.ext_req),   32'd0);
      check("to_if_rvalid",   32'(bus.if_rvalid), 32'd1);
      check("to_if_err",      32'(bus.if_err),    32'd1);
      check("to_if_rdata",    bus.if_rdata,       NOP_INSN);
      step();
      check("to_err_pulse",   32'(bus.if_err),    32'd0);
`else
      n = 0;
      repeat (40) begin
         step();
         if (bus.ext_req) n++;
      end
      check("noto_ext_req_held", 32'(n),           32'd40);
      check("noto_if_err",       32'(bus.if_err),  32'd0);
      bus.ext_ready = 1'b1; bus.ext_data_in = 32'h00C0_FFEE;
      step();
      check("noto_if_rvalid",    32'(bus.if_rvalid), 32'd1);
      check("noto_if_rdata",     bus.if_rdata,       32'h00C0_FFEE);
      bus.ext_ready = 1'b0;
      step();
`endif

      // Both requesting forever: fetch gets every (MAX_BURST+1)-th grant
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h0000_0020; bus.ls_be = 4'hF;
      bus.ext_ready = 1'b1;
      grants = 0;
      n = 0;
      while (grants < 10 && n < 60) begin
         step();
         n++;
         if (bus.if_gnt || bus.ls_gnt) begin
            saw_ls = (grants % 5) != 4;
            tmp    = {30'd0, bus.if_gnt, bus.ls_gnt};
            check($sformatf("starve_grant%0d", grants), tmp, saw_ls ? 32'd1 : 32'd2);
            grants++;
         end
      end
      check("starve_grant_count", 32'(grants), 32'd10);
      idle_inputs();
      repeat (3) step();

      reset = 1'b1;
      #2 reset = 1'b0;
      step();
      random_test(1500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
